// File: rtl/swap_chk_pkg.sv
// Shared definitions for the swap pair checker.
//   STATE_W : width of the exported FSM state
//   state_t : FSM encoding (IDLE=0, PRIME=1, TRACK=2, FAULT=3)
//   STREAK_W: width of the consecutive-mismatch counter (MAX_ERR up to 255)
package swap_chk_pkg;

  localparam int STATE_W  = 2;
  localparam int STREAK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/swap_pair_checker_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset to zero
//   clr   : synchronous clear to zero (below reset in priority)
//   inc   : count up by one; holds at all-ones instead of wrapping
//   q     : registered count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/swap_pair_checker.sv
// Observer for a two-register swap stage. Every clock it checks that the
// stage's outputs have exchanged (x_now == y_prev, y_now == x_prev), counts
// good swaps and mismatches, and latches a sticky fault after MAX_ERR
// consecutive mismatches.
//   clk        : rising-edge clock shared with the swap stage
//   rst_n      : synchronous active-low reset
//   en         : checking enable; dropping it loses lock
//   clear      : synchronous clear of counters, fault and FSM
//   x_in, y_in : swap stage outputs
//   swap_count : saturating count of correct swaps
//   err_count  : saturating count of mismatches
//   locked     : high while tracking
//   fault      : sticky fault, high in FAULT
//   state      : FSM state for debug
module swap_pair_checker
  import swap_chk_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int MAX_ERR = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  output logic [CNT_W-1:0]   swap_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               locked,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  localparam logic [STREAK_W-1:0] MAX_ERR_V = STREAK_W'(MAX_ERR);

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    prev_x_reg, prev_x_next;
  logic [WIDTH-1:0]    prev_y_reg, prev_y_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic                locked_reg, fault_reg;
  logic                match;
  logic                swap_inc, err_inc;

  // A correct swap means each output now holds what the other held last cycle.
  assign match = (x_in == prev_y_reg) && (y_in == prev_x_reg);

  always_comb begin
    state_next  = state_reg;
    prev_x_next = prev_x_reg;
    prev_y_next = prev_y_reg;
    streak_next = streak_reg;
    swap_inc    = 1'b0;
    err_inc     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        // First sample after (re)lock only seeds the history; a glitch here
        // is never counted.
        prev_x_next = x_in;
        prev_y_next = y_in;
        state_next  = en ? ST_TRACK : ST_IDLE;
      end
      ST_TRACK: begin
        if (!en) begin
          // Losing enable beats any pending mismatch: no compare, no capture.
          state_next  = ST_IDLE;
          streak_next = '0;
        end else begin
          prev_x_next = x_in;
          prev_y_next = y_in;
          if (match) begin
            swap_inc    = 1'b1;
            streak_next = '0;
          end else begin
            err_inc     = 1'b1;
            streak_next = streak_reg + STREAK_W'(1);
            if (streak_next == MAX_ERR_V) state_next = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        // Sticky: only clear or reset leave this state.
        state_next = ST_FAULT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      // Reset and clear have identical effect; reset is listed first only
      // for readability of the priority.
      state_reg  <= ST_IDLE;
      prev_x_reg <= '0;
      prev_y_reg <= '0;
      streak_reg <= '0;
      locked_reg <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prev_x_reg <= prev_x_next;
      prev_y_reg <= prev_y_next;
      streak_reg <= streak_next;
      // Status flags are registered from the next state so they line up
      // with the state register.
      locked_reg <= (state_next == ST_TRACK);
      fault_reg  <= (state_next == ST_FAULT);
    end
  end

  // Counter 0 counts good swaps, counter 1 counts mismatches.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [2];

  assign cnt_inc = {err_inc, swap_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clear),
      .inc  (cnt_inc[gi]),
      .q    (cnt_q[gi])
    );
  end

  assign swap_count = cnt_q[0];
  assign err_count  = cnt_q[1];
  assign locked     = locked_reg;
  assign fault      = fault_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_swap_pair_checker.sv
module tb_swap_pair_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // ---------------- WIDTH=1 instance fed by a real swap stage -------------
  logic       en1;
  logic       sx, sy;
  logic [7:0] sc1, ec1;
  logic       lk1, ft1;
  logic [1:0] st1;

  always @(posedge clk) begin
    if (!rst_n) begin
      sx <= 1'b1;
      sy <= 1'b0;
    end else begin
      sx <= sy;
      sy <= sx;
    end
  end

  swap_pair_checker #(.WIDTH(1), .CNT_W(8), .MAX_ERR(3)) u_w1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clear(1'b0),
    .x_in(sx), .y_in(sy),
    .swap_count(sc1), .err_count(ec1), .locked(lk1), .fault(ft1), .state(st1)
  );

  // ---------------- WIDTH=4, CNT_W=4 instance, directed stimulus ----------
  logic       en, clear;
  logic [3:0] x, y;
  logic [3:0] sc, ec;
  logic       lk, ft;
  logic [1:0] st;

  swap_pair_checker #(.WIDTH(4), .CNT_W(4), .MAX_ERR(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .x_in(x), .y_in(y),
    .swap_count(sc), .err_count(ec), .locked(lk), .fault(ft), .state(st)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en1 = 1'b0; en = 1'b0; clear = 1'b0; x = 4'h0; y = 4'h0;
    tick();
    tick();
    chk("w1 reset state", 32'(st1), 0);
    chk("w4 reset swap", 32'(sc), 0);
    chk("w4 reset err", 32'(ec), 0);
    chk("w4 reset locked", 32'(lk), 0);
    chk("w4 reset fault", 32'(ft), 0);

    // Test 1: real swap stage, width 1
    rst_n = 1'b1; en1 = 1'b1;
    tick();
    chk("w1 prime", 32'(st1), 1);
    tick();
    chk("w1 track", 32'(st1), 2);
    for (int i = 0; i < 10; i++) tick();
    chk("w1 swap10", 32'(sc1), 10);
    chk("w1 err0", 32'(ec1), 0);
    chk("w1 locked", 32'(lk1), 1);
    chk("w1 fault", 32'(ft1), 0);
    en1 = 1'b0;

    // Test 2: no-swap pattern drives FAULT
    en = 1'b1; x = 4'h3; y = 4'hA;
    tick();
    chk("t2 prime", 32'(st), 1);
    tick();
    chk("t2 track", 32'(st), 2);
    for (int i = 0; i < 3; i++) tick();
    chk("t2 err3", 32'(ec), 3);
    chk("t2 state fault", 32'(st), 3);
    chk("t2 fault", 32'(ft), 1);
    chk("t2 locked", 32'(lk), 0);
    en = 1'b0; tick();
    en = 1'b1; tick();
    en = 1'b0; tick();
    chk("t2 frozen err", 32'(ec), 3);
    chk("t2 frozen swap", 32'(sc), 0);
    chk("t2 still fault", 32'(st), 3);

    // Test 3: streak reset by a good swap
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t3 clear state", 32'(st), 0);
    chk("t3 clear err", 32'(ec), 0);
    chk("t3 clear fault", 32'(ft), 0);
    en = 1'b1; x = 4'h3; y = 4'hA;
    tick(); tick();
    tick(); tick();                      // two mismatches
    x = 4'hA; y = 4'h3; tick();          // good swap
    tick(); tick();                      // same value again: two mismatches
    chk("t3 err4", 32'(ec), 4);
    chk("t3 swap1", 32'(sc), 1);
    chk("t3 no fault", 32'(st), 2);
    chk("t3 fault flag", 32'(ft), 0);

    // Test 4: saturation of swap_count, then clear
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin x = 4'h3; y = 4'hA; end
      else            begin x = 4'hA; y = 4'h3; end
      tick();
    end
    chk("t4 swap sat", 32'(sc), 4'hF);
    chk("t4 err kept", 32'(ec), 4);
    clear = 1'b1; tick(); clear = 1'b0; en = 1'b0;
    chk("t4 clr swap", 32'(sc), 0);
    chk("t4 clr err", 32'(ec), 0);
    chk("t4 clr locked", 32'(lk), 0);
    chk("t4 clr state", 32'(st), 0);

    // Test 5: relock absorbs a corrupt first sample
    en = 1'b1; x = 4'h1; y = 4'h2;
    tick(); tick();
    x = 4'h2; y = 4'h1; tick();
    chk("t5 track", 32'(st), 2);
    chk("t5 swap1", 32'(sc), 1);
    en = 1'b0; tick();
    chk("t5 idle", 32'(st), 0);
    en = 1'b1; tick();
    chk("t5 prime", 32'(st), 1);
    x = 4'hF; y = 4'hE; tick();
    chk("t5 retrack", 32'(st), 2);
    chk("t5 err kept", 32'(ec), 0);
    x = 4'hE; y = 4'hF; tick();
    chk("t5 swap2", 32'(sc), 2);
    chk("t5 err0", 32'(ec), 0);

    // Test 6: reset with clear during FAULT, then fixed point x==y
    tick(); tick(); tick();
    chk("t6 fault", 32'(st), 3);
    rst_n = 1'b0; clear = 1'b1; tick();
    rst_n = 1'b1; clear = 1'b0;
    chk("t6 rst state", 32'(st), 0);
    chk("t6 rst err", 32'(ec), 0);
    chk("t6 rst fault", 32'(ft), 0);
    x = 4'h5; y = 4'h5; tick(); tick();
    tick(); tick(); tick();
    chk("t6 fixed point", 32'(sc), 3);

    // Test 7: en=0 on the would-be MAX_ERR-th mismatch wins
    x = 4'h6; y = 4'h6; tick();
    x = 4'h7; y = 4'h7; tick();
    chk("t7 err2", 32'(ec), 2);
    en = 1'b0; x = 4'h8; y = 4'h8; tick();
    chk("t7 idle", 32'(st), 0);
    chk("t7 err kept", 32'(ec), 2);
    chk("t7 no fault", 32'(ft), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swap_pair_checker.md
Name: swap_pair_checker

Overview:
- Downstream consumer of the two-register swap stage: samples the stage's x/y outputs every clock and checks the swap invariant (x_now == y_prev, y_now == x_prev).
- Counts good swaps and mismatches, tracks a run of consecutive mismatches, and raises a sticky fault flag.
- Gives the swap stage a self-checking observer for bench and board use. Exposes lock status and FSM state for debug.

Parameters:
WIDTH, 1, bit width of each of x_in and y_in
CNT_W, 8, width of swap_count and err_count
MAX_ERR, 3, consecutive mismatches that force FAULT (legal range 1..255)

Ports:
clk  input  1  rising-edge clock, same clock as the swap stage
rst_n  input  1  reset, synchronous and active-low
en  input  1  checking enable; low drops lock
clear  input  1  synchronous clear of counters, fault and FSM
x_in  input  WIDTH  swap stage x output
y_in  input  WIDTH  swap stage y output
swap_count  output  CNT_W  saturating count of correct swaps
err_count  output  CNT_W  saturating count of mismatches
locked  output  1  high in TRACK
fault  output  1  sticky; high in FAULT
state  output  2  FSM state encoding

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. swap_count=0, err_count=0, locked=0, fault=0. Internal prev_x, prev_y and streak are all 0.
- Priority at each edge: rst_n, then clear, then FSM.
- clear=1: same effect as reset. Legal in any state, including FAULT.
- All outputs are registered. A sample taken at edge N shows in the counters after edge N.
- FSM states: IDLE=0, PRIME=1, TRACK=2, FAULT=3.
  - IDLE: en=1 -> PRIME. Otherwise stay.
  - PRIME: capture prev_x<=x_in and prev_y<=y_in. No comparison is made. Next state is TRACK if en=1, else IDLE.
  - TRACK, en=1: compare x_in==prev_y and y_in==prev_x.
    - Match: swap_count+1 (saturate at 2^CNT_W-1), streak<=0.
    - Mismatch: err_count+1 (saturating), streak+1.
    - If the new streak equals MAX_ERR -> FAULT.
    - prev_x and prev_y are updated with x_in and y_in every TRACK cycle, match or not.
  - TRACK, en=0: go to IDLE with no comparison and no capture. Counters are kept. streak<=0. Re-enable always goes through PRIME (relock).
  - FAULT: sticky. Counters freeze and en is ignored. Exit only by clear or rst_n, both to IDLE.
- locked=1 only in TRACK. fault=1 only in FAULT.
- x_in==y_in held constant is a legal fixed point of the swap. It counts as a match every cycle.
- The first sample after relock is never compared, so a glitch in that cycle is not counted.
- Saturation: both counters stick at all-ones. There is no wrap-around.
- Simultaneous events:
  - Mismatch on the MAX_ERR-th cycle together with en=0: en=0 wins, giving IDLE, no count, no fault.
  - clear together with a mismatch: clear wins, all zero.

Decomposition:
- Package swap_chk_pkg holds the state encoding constants (ST_IDLE, ST_PRIME, ST_TRACK, ST_FAULT) and the 2-bit state width.
- One sub-module, sat_counter, is instantiated twice for swap_count and err_count. Parameter W. Inputs clk, rst_n, clr, inc. Output q.
- The FSM and comparator stay in the top module.

Test Plan:
- Reset release, en=1, WIDTH=1, driven from a real swap stage with x=1, y=0 -> state 0, 1, 2. After 10 TRACK cycles: swap_count=10, err_count=0, locked=1, fault=0.
- WIDTH=4, TRACK with prev=(x=4'h3, y=4'hA); drive x_in=4'h3, y_in=4'hA (no swap) for 3 cycles with MAX_ERR=3 -> err_count=3, state=FAULT, fault=1. Further en toggles leave counts frozen.
- 2 mismatches, then 1 good swap, then 2 mismatches (MAX_ERR=3) -> err_count=4, swap_count=1, no FAULT (streak reset by the match).
- CNT_W=4 with 20 good swaps -> swap_count=4'hF held. Then clear=1 -> all outputs 0, state=IDLE.
- In TRACK, en=0 for 1 cycle, then a corrupt value on the first cycle back -> state 2, 0, 1, 2. The corrupt sample is absorbed in PRIME, so err_count is unchanged.
- rst_n=0 and clear=1 in the same cycle during FAULT, then rst_n=1 -> IDLE, zeros. x_in==y_in=4'h5 constant in TRACK -> swap_count increments each cycle.
